amf_window_fetch: RTL
=====================

// Module: amf_window_fetch
// PURPOSE
// Upstream stage of the adaptive median filter core. Accepts a window request
// (centre pixel + window size 3/5/7), reads the k*k neighbourhood from the
// image RAM (1-cycle read latency) and streams pixels row-major to the filter
// over a valid/ready handshake. Out-of-image positions use border replication.
// PARAMETERS
// IMG_W   64  image width in pixels
// IMG_H   64  image height in pixels
// PIX_W   8   pixel width in bits
// ADDR_W  12  RAM address width; must be >= clog2(IMG_W*IMG_H)
// PORTS
// clk        in   1       clock, all logic on rising edge
// rst        in   1       synchronous reset, active-high
// req_valid  in   1       window request valid
// req_ready  out  1       block idle, request accepted when req_valid&req_ready
// req_row    in   ADDR_W  centre row (0..IMG_H-1)
// req_col    in   ADDR_W  centre column (0..IMG_W-1)
// req_size   in   2       0:3x3  1:5x5  2:7x7  3:treated as 3x3
// mem_rd     out  1       RAM read strobe
// mem_addr   out  ADDR_W  RAM address = row*IMG_W + col
// mem_data   in   PIX_W   RAM read data, valid the cycle after mem_rd
// pix_valid  out  1       pix_data valid
// pix_ready  in   1       consumer accepts pixel when pix_valid&pix_ready
// pix_data   out  PIX_W   window pixel
// pix_last   out  1       high with final pixel (k*k-th) of the window
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1, mem_rd=0, mem_addr=0, pix_valid=0,
//   pix_data=0, pix_last=0; window counters cleared. Reset mid-window aborts
//   it; partial window is discarded, no further beats issued.
// - FSM: IDLE -> RD -> CAP -> OUT -> (RD | IDLE).
//   IDLE: req_ready=1; on req_valid latch row/col/k, clear wi,wj, go RD.
//   RD:   mem_rd=1 for exactly one cycle with address of (wi,wj); go CAP.
//   CAP:  register mem_data into pix_data, pix_valid=1, pix_last=(wi==k-1 &&
//         wj==k-1); go OUT.
//   OUT:  hold pix_data/pix_valid/pix_last stable until pix_ready. On accept:
//         pix_valid=0; if last go IDLE, else advance wj (wrap to 0, wi+1) and
//         go RD. Ready low any number of cycles -> no mem_rd issued.
// - req_ready=0 in all states except IDLE; requests outside IDLE are ignored.
// - Coordinates: r = req_row + wi - (k-1)/2, c = req_col + wj - (k-1)/2,
//   computed signed (ADDR_W+2 bits); clamp r to [0,IMG_H-1], c to [0,IMG_W-1].
//   Address = r*IMG_W + c, truncated to ADDR_W.
// - Timing with pix_ready tied high: one pixel every 3 cycles; first pix_valid
//   2 cycles after request accept; k*k beats per window (9/25/49).
// - Back-to-back: new request may be accepted the cycle after the last beat
//   is accepted (IDLE for one cycle).
// - Only one RAM read outstanding at any time; mem_addr holds last value
//   when mem_rd=0.
// TESTING
// RAM model mem[a]=a[7:0]; pix_ready high unless stated.
// 1 req (10,10) size 0 -> mem_addr 585,586,587,649,650,651,713,714,715;
//   pix_data 73,74,75,137,138,139,201,202,203; pix_last only on 9th beat.
// 2 req (0,0) size 0 -> addrs 0,0,1,0,0,1,64,64,65 (replication at corner).
// 3 req (63,63) size 2 -> 49 beats, every addr in {60..63}*64+{60..63},
//   first addr 3900, last 4095; pix_last on beat 49 only; then req_ready=1.
// 4 req (10,10) size 1, pix_ready low 5 cycles on beat 3 -> pix_data/pix_last
//   stable, mem_rd=0 throughout stall; 25 beats total, none dropped/duplicated.
// 5 assert rst during beat 4 of a 5x5 window -> next cycle pix_valid=0,
//   mem_rd=0, req_ready=1; new 3x3 request then produces clean 9-beat window.
// 6 req_size=3 -> behaves as 3x3 (9 beats); req_valid pulsed while busy ignored.

Source files
------------

// File: rtl/amf_window_fetch.sv
// Window fetch stage of the adaptive median filter: reads a k*k neighbourhood
// around a centre pixel with border replication and streams it row-major.
module amf_window_fetch #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_row,
   input  logic [ADDR_W-1:0] req_col,
   input  logic [1:0]        req_size,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_last
);

   localparam int SW = ADDR_W + 2;
   localparam logic signed [SW-1:0] R_MAX = SW'(IMG_H - 1);
   localparam logic signed [SW-1:0] C_MAX = SW'(IMG_W - 1);
   localparam logic [ADDR_W-1:0]    W_L   = ADDR_W'(IMG_W);

   typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] row_q, col_q, addr_hold, addr_calc, r_cl, c_cl;
   logic [2:0]        half_q, km1, wi, wj;
   logic signed [SW-1:0] r_s, c_s;
   logic              win_last;

   assign km1      = {half_q[1:0], 1'b0};
   assign win_last = (wi == km1) && (wj == km1);

   // Window position relative to the centre, clamped to the image (replication).
   always_comb begin
      r_s = $signed({2'b00, row_q}) + $signed({{(SW-3){1'b0}}, wi})
          - $signed({{(SW-3){1'b0}}, half_q});
      c_s = $signed({2'b00, col_q}) + $signed({{(SW-3){1'b0}}, wj})
          - $signed({{(SW-3){1'b0}}, half_q});
      if (r_s[SW-1])      r_cl = '0;
      else if (r_s > R_MAX) r_cl = ADDR_W'(IMG_H - 1);
      else                r_cl = r_s[ADDR_W-1:0];
      if (c_s[SW-1])      c_cl = '0;
      else if (c_s > C_MAX) c_cl = ADDR_W'(IMG_W - 1);
      else                c_cl = c_s[ADDR_W-1:0];
      addr_calc = r_cl * W_L + c_cl;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = addr_hold;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = RD;
         end
         RD: begin
            mem_rd   = 1'b1;
            mem_addr = addr_calc;
            state_nx = CAP;
         end
         CAP: state_nx = OUT;
         OUT: if (pix_ready) state_nx = pix_last ? IDLE : RD;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the values they held before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q     <= '0;
         col_q     <= '0;
         half_q    <= 3'd1;
         wi        <= '0;
         wj        <= '0;
         addr_hold <= '0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               row_q <= req_row;
               col_q <= req_col;
               wi    <= '0;
               wj    <= '0;
               case (req_size)
                  2'd1:    half_q <= 3'd2;
                  2'd2:    half_q <= 3'd3;
                  default: half_q <= 3'd1;
               endcase
            end
            RD: addr_hold <= addr_calc;
            CAP: begin
               pix_data  <= mem_data;
               pix_valid <= 1'b1;
               pix_last  <= win_last;
            end
            OUT: if (pix_ready) begin
               pix_valid <= 1'b0;
               pix_last  <= 1'b0;
               if (!win_last) begin
                  if (wj == km1) begin
                     wj <= '0;
                     wi <= wi + 3'd1;
                  end else begin
                     wj <= wj + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
